// File: rtl/store_buffer.sv
// Store buffer: a small circular FIFO of committed stores that drains to
// memory in program order and forwards data to two execute-stage load ports.
// A load that overlaps a buffered word but cannot be satisfied exactly is
// flagged as a conflict so the pipeline can retry it.

package store_buffer_pkg;

  // Access width of a load or store.
  typedef enum logic [1:0] {
    LDST_BYTE = 2'd0,
    LDST_HALF = 2'd1,
    LDST_WORD = 2'd2
  } ldst_mode;

  // One buffered store.
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    ldst_mode    mode;
  } sb_entry_t;

endpackage

module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int DEPTH_LOG = 2
) (
  input  logic        clk,
  input  logic        reset,

  // Commit-stage store input
  input  logic        we,
  input  logic [31:0] wa,
  input  logic [31:0] wd,
  input  ldst_mode    wm,

  // Load lookup ports
  input  logic [31:0] la       [2],
  input  ldst_mode    lm       [2],
  output logic        fwd_hit  [2],
  output logic [31:0] fwd_data [2],
  output logic        conflict [2],

  // Drain interface to memory
  output logic        mem_req,
  output logic [31:0] mem_wa,
  output logic [31:0] mem_wd,
  output ldst_mode    mem_wm,
  input  logic        mem_ack,

  // Status
  output logic        full,
  output logic        empty,
  output logic        overflow
);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [DEPTH_LOG:0]   head_q, head_d;
  logic [DEPTH_LOG:0]   tail_q, tail_d;
  logic                 overflow_q, overflow_d;
  sb_entry_t            entries_q [DEPTH];

  logic [DEPTH_LOG-1:0] head_idx;
  logic [DEPTH_LOG-1:0] tail_idx;
  logic [DEPTH_LOG:0]   count;

  logic                 push;
  logic                 pop;
  logic                 drop;

  logic                 match_found [2];
  sb_entry_t            match_entry [2];

  // Physical slot holding the k-th oldest entry counted from the head.
  function automatic logic [DEPTH_LOG-1:0] slot_of(
    input logic [DEPTH_LOG-1:0] base,
    input int                   k
  );
    return base + DEPTH_LOG'(k);
  endfunction

  // ---------------------------------------------------------------------------
  // Pointer decode and status
  // ---------------------------------------------------------------------------
  // The extra pointer MSB toggles on every wrap, so equal indices with
  // different MSBs mean the buffer is full rather than empty.
  assign head_idx = head_q[DEPTH_LOG-1:0];
  assign tail_idx = tail_q[DEPTH_LOG-1:0];
  assign count    = tail_q - head_q;

  assign empty    = (head_q == tail_q);
  assign full     = (head_idx == tail_idx) && (head_q[DEPTH_LOG] != tail_q[DEPTH_LOG]);
  assign overflow = overflow_q;

  // Head entry is presented to memory until it is acknowledged.
  assign mem_req  = !empty;
  assign mem_wa   = entries_q[head_idx].addr;
  assign mem_wd   = entries_q[head_idx].data;
  assign mem_wm   = entries_q[head_idx].mode;

  // An ack only counts while a request is outstanding. A pop frees a slot in
  // the same cycle, so a full buffer can still accept a store alongside it.
  assign pop  = mem_req && mem_ack;
  assign push = we && (!full || pop);
  assign drop = we && full && !pop;

  // ---------------------------------------------------------------------------
  // Next-state logic for pointers and the sticky overflow flag
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    head_d     = head_q;
    tail_d     = tail_q;
    overflow_d = overflow_q;

    if (pop) begin
      head_d = head_q + (DEPTH_LOG+1)'(1);
    end
    if (push) begin
      tail_d = tail_q + (DEPTH_LOG+1)'(1);
    end
    if (drop) begin
      overflow_d = 1'b1;
    end
  end

  // Pointer and overflow registers; reset discards every buffered store.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      head_q     <= '0;
      tail_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      overflow_q <= overflow_d;
    end
  end

  // Entry storage write at the tail.
  always_ff @(posedge clk) begin
    // NOTE: the storage array is deliberately not reset; validity is carried
    // entirely by the pointers, so stale contents are never observed.
    if (push) begin
      entries_q[tail_idx] <= '{addr: wa, data: wd, mode: wm};
    end
  end

  // ---------------------------------------------------------------------------
  // Load lookup
  // ---------------------------------------------------------------------------
  // Walk valid entries oldest to youngest; later matches overwrite earlier
  // ones so the youngest word match wins. The store arriving this cycle is
  // not yet in the buffer and is not searched; an entry being popped this
  // cycle is still valid and still participates.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      match_found[p] = 1'b0;
      match_entry[p] = '0;
      for (int k = 0; k < DEPTH; k++) begin
        if (((DEPTH_LOG+1)'(k) < count) &&
            (entries_q[slot_of(head_idx, k)].addr[31:2] == la[p][31:2])) begin
          match_found[p] = 1'b1;
          match_entry[p] = entries_q[slot_of(head_idx, k)];
        end
      end
    end
  end

  // Resolve the youngest match into forward, conflict or miss per port.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      fwd_hit[p]  = 1'b0;
      conflict[p] = 1'b0;
      fwd_data[p] = '0;
      if (match_found[p]) begin
        if ((match_entry[p].addr == la[p]) && (match_entry[p].mode == lm[p])) begin
          fwd_hit[p]  = 1'b1;
          fwd_data[p] = match_entry[p].data;
        end else begin
          conflict[p] = 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: directed scenarios plus a randomized
// run compared against a queue-based model of the buffer.

module tb_store_buffer;
  import store_buffer_pkg::*;

  localparam int DEPTH     = 4;
  localparam int DEPTH_LOG = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        we;
  logic [31:0] wa;
  logic [31:0] wd;
  ldst_mode    wm;
  logic [31:0] la       [2];
  ldst_mode    lm       [2];
  logic        fwd_hit  [2];
  logic [31:0] fwd_data [2];
  logic        conflict [2];
  logic        mem_req;
  logic [31:0] mem_wa;
  logic [31:0] mem_wd;
  ldst_mode    mem_wm;
  logic        mem_ack;
  logic        full;
  logic        empty;
  logic        overflow;

  int checks   = 0;
  int failures = 0;

  // Reference model: the buffer is just an ordered list of stores.
  sb_entry_t model_q[$];
  bit        model_ovf;

  store_buffer #(.DEPTH(DEPTH), .DEPTH_LOG(DEPTH_LOG)) dut (
    .clk      (clk),
    .reset    (rst_n),
    .we       (we),
    .wa       (wa),
    .wd       (wd),
    .wm       (wm),
    .la       (la),
    .lm       (lm),
    .fwd_hit  (fwd_hit),
    .fwd_data (fwd_data),
    .conflict (conflict),
    .mem_req  (mem_req),
    .mem_wa   (mem_wa),
    .mem_wd   (mem_wd),
    .mem_wm   (mem_wm),
    .mem_ack  (mem_ack),
    .full     (full),
    .empty    (empty),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // Youngest store touching the same word decides the outcome.
  function automatic void model_lookup(input logic [31:0] a, input ldst_mode m,
                                       output bit hit, output bit conf,
                                       output logic [31:0] data);
    hit  = 1'b0;
    conf = 1'b0;
    data = '0;
    for (int k = model_q.size() - 1; k >= 0; k--) begin
      if (model_q[k].addr[31:2] == a[31:2]) begin
        if (model_q[k].addr == a && model_q[k].mode == m) begin
          hit  = 1'b1;
          data = model_q[k].data;
        end else begin
          conf = 1'b1;
        end
        break;
      end
    end
  endfunction

  task automatic set_idle();
    we      = 1'b0;
    wa      = '0;
    wd      = '0;
    wm      = LDST_WORD;
    mem_ack = 1'b0;
    for (int p = 0; p < 2; p++) begin
      la[p] = 32'hFFFF_FFF0;
      lm[p] = LDST_WORD;
    end
  endtask

  // Clock one edge with the current inputs, updating the model alongside.
  // Called in the low phase; returns at the next falling edge.
  task automatic cycle();
    bit do_pop, do_push;
    do_pop  = (model_q.size() != 0) && mem_ack;
    do_push = we && ((model_q.size() < DEPTH) || do_pop);
    if (we && !do_push) model_ovf = 1'b1;
    @(posedge clk);
    if (do_pop) void'(model_q.pop_front());
    if (do_push) model_q.push_back('{addr: wa, data: wd, mode: wm});
    @(negedge clk);
  endtask

  task automatic do_reset();
    set_idle();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_q.delete();
    model_ovf = 1'b0;
  endtask

  task automatic push_word(input logic [31:0] a, input logic [31:0] d);
    we = 1'b1; wa = a; wd = d; wm = LDST_WORD;
    cycle();
    we = 1'b0;
  endtask

  task automatic test_reset();
    set_idle();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL reset_empty: got %b exp 1", empty); end
    checks++; if (full !== 1'b0) begin failures++; $display("FAIL reset_full: got %b exp 0", full); end
    checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL reset_mem_req: got %b exp 0", mem_req); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow: got %b exp 0", overflow); end
    checks++; if (fwd_hit[0] !== 1'b0 || conflict[0] !== 1'b0) begin failures++; $display("FAIL reset_lookup: hit %b conflict %b exp 0 0", fwd_hit[0], conflict[0]); end
    rst_n = 1'b1;
    model_q.delete();
    model_ovf = 1'b0;
    @(negedge clk);
    #1;
    checks++; if (empty !== 1'b1 || mem_req !== 1'b0) begin failures++; $display("FAIL reset_release: empty %b mem_req %b exp 1 0", empty, mem_req); end
  endtask

  task automatic test_single_push();
    @(negedge clk);
    push_word(32'h100, 32'hDEAD_BEEF);
    la[0] = 32'h100; lm[0] = LDST_WORD;
    #1;
    checks++; if (mem_req !== 1'b1) begin failures++; $display("FAIL single_mem_req: got %b exp 1", mem_req); end
    checks++; if (mem_wa !== 32'h100) begin failures++; $display("FAIL single_mem_wa: got %h exp 00000100", mem_wa); end
    checks++; if (mem_wd !== 32'hDEAD_BEEF) begin failures++; $display("FAIL single_mem_wd: got %h exp deadbeef", mem_wd); end
    checks++; if (mem_wm !== LDST_WORD) begin failures++; $display("FAIL single_mem_wm: got %0d exp %0d", mem_wm, LDST_WORD); end
    checks++; if (empty !== 1'b0) begin failures++; $display("FAIL single_empty: got %b exp 0", empty); end
    checks++; if (fwd_hit[0] !== 1'b1) begin failures++; $display("FAIL single_fwd_hit: got %b exp 1", fwd_hit[0]); end
    checks++; if (fwd_data[0] !== 32'hDEAD_BEEF) begin failures++; $display("FAIL single_fwd_data: got %h exp deadbeef", fwd_data[0]); end
    mem_ack = 1'b1;
    cycle();
    mem_ack = 1'b0;
    #1;
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL single_drained: empty %b exp 1", empty); end
    checks++; if (fwd_hit[0] !== 1'b0) begin failures++; $display("FAIL single_hit_after_drain: got %b exp 0", fwd_hit[0]); end
  endtask

  task automatic test_full_overflow();
    logic [31:0] exp_a [4];
    logic [31:0] exp_d [4];
    set_idle();
    for (int j = 0; j < 4; j++) begin
      exp_a[j] = 32'h500 + 32'(4 * j);
      exp_d[j] = $urandom;
      push_word(exp_a[j], exp_d[j]);
    end
    #1;
    checks++; if (full !== 1'b1) begin failures++; $display("FAIL full_after_4: got %b exp 1", full); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_before_drop: got %b exp 0", overflow); end
    push_word(32'h600, 32'h5555_AAAA);
    #1;
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_after_drop: got %b exp 1", overflow); end
    checks++; if (full !== 1'b1) begin failures++; $display("FAIL full_after_drop: got %b exp 1", full); end
    for (int j = 0; j < 4; j++) begin
      #1;
      checks++; if (mem_wa !== exp_a[j]) begin failures++; $display("FAIL drain_wa[%0d]: got %h exp %h", j, mem_wa, exp_a[j]); end
      checks++; if (mem_wd !== exp_d[j]) begin failures++; $display("FAIL drain_wd[%0d]: got %h exp %h", j, mem_wd, exp_d[j]); end
      mem_ack = 1'b1;
      cycle();
      mem_ack = 1'b0;
    end
    #1;
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL drain_empty: got %b exp 1", empty); end
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_sticky: got %b exp 1", overflow); end
  endtask

  task automatic test_full_push_pop();
    logic [31:0] exp_a [4];
    do_reset();
    for (int j = 0; j < 4; j++) push_word(32'h700 + 32'(4 * j), 32'h7000 + 32'(j));
    we = 1'b1; wa = 32'h7F0; wd = 32'hCAFE_F00D; wm = LDST_WORD; mem_ack = 1'b1;
    #1;
    checks++; if (mem_wa !== 32'h700) begin failures++; $display("FAIL pp_head_before: got %h exp 00000700", mem_wa); end
    cycle();
    we = 1'b0; mem_ack = 1'b0;
    #1;
    checks++; if (full !== 1'b1) begin failures++; $display("FAIL pp_full: got %b exp 1", full); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL pp_overflow: got %b exp 0", overflow); end
    exp_a = '{32'h704, 32'h708, 32'h70C, 32'h7F0};
    for (int j = 0; j < 4; j++) begin
      #1;
      checks++; if (mem_wa !== exp_a[j]) begin failures++; $display("FAIL pp_drain_wa[%0d]: got %h exp %h", j, mem_wa, exp_a[j]); end
      mem_ack = 1'b1;
      cycle();
      mem_ack = 1'b0;
    end
    #1;
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL pp_empty: got %b exp 1", empty); end
  endtask

  task automatic test_forwarding();
    set_idle();
    push_word(32'h200, 32'h1111_1111);
    push_word(32'h200, 32'h2222_2222);
    la[0] = 32'h200; lm[0] = LDST_WORD;
    la[1] = 32'h202; lm[1] = LDST_HALF;
    #1;
    checks++; if (fwd_hit[0] !== 1'b1 || fwd_data[0] !== 32'h2222_2222) begin failures++; $display("FAIL fwd_youngest: hit %b data %h exp 1 22222222", fwd_hit[0], fwd_data[0]); end
    checks++; if (conflict[0] !== 1'b0) begin failures++; $display("FAIL fwd_youngest_conflict: got %b exp 0", conflict[0]); end
    checks++; if (conflict[1] !== 1'b1 || fwd_hit[1] !== 1'b0) begin failures++; $display("FAIL fwd_half_conflict: conflict %b hit %b exp 1 0", conflict[1], fwd_hit[1]); end
    la[0] = 32'h300; la[1] = 32'h300; lm[1] = LDST_WORD;
    #1;
    for (int p = 0; p < 2; p++) begin
      checks++; if (fwd_hit[p] !== 1'b0 || conflict[p] !== 1'b0 || fwd_data[p] !== 32'h0) begin failures++; $display("FAIL fwd_miss[%0d]: hit %b conflict %b data %h exp 0 0 0", p, fwd_hit[p], conflict[p], fwd_data[p]); end
    end
    // Entry popping this cycle still forwards.
    la[1] = 32'h200; mem_ack = 1'b1;
    #1;
    checks++; if (fwd_hit[1] !== 1'b1 || fwd_data[1] !== 32'h2222_2222) begin failures++; $display("FAIL fwd_during_pop: hit %b data %h exp 1 22222222", fwd_hit[1], fwd_data[1]); end
    cycle();
    cycle();
    mem_ack = 1'b0;
    #1;
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL fwd_drained: got %b exp 1", empty); end
  endtask

  task automatic test_wrap();
    logic [31:0] pa [6];
    logic [31:0] pd [6];
    int pop_idx = 0;
    set_idle();
    for (int j = 0; j < 6; j++) begin
      pa[j] = 32'h800 + 32'(4 * j);
      pd[j] = $urandom;
      we = 1'b1; wa = pa[j]; wd = pd[j]; wm = LDST_WORD;
      mem_ack = (j >= 2);
      #1;
      if (mem_ack) begin
        checks++; if (mem_wa !== pa[pop_idx] || mem_wd !== pd[pop_idx]) begin failures++; $display("FAIL wrap_order[%0d]: got %h/%h exp %h/%h", pop_idx, mem_wa, mem_wd, pa[pop_idx], pd[pop_idx]); end
        pop_idx++;
      end
      cycle();
    end
    set_idle();
    la[0] = pa[5]; lm[0] = LDST_WORD;
    la[1] = pa[0]; lm[1] = LDST_WORD;
    #1;
    checks++; if (fwd_hit[0] !== 1'b1 || fwd_data[0] !== pd[5]) begin failures++; $display("FAIL wrap_fwd: hit %b data %h exp 1 %h", fwd_hit[0], fwd_data[0], pd[5]); end
    checks++; if (fwd_hit[1] !== 1'b0 || conflict[1] !== 1'b0) begin failures++; $display("FAIL wrap_popped_miss: hit %b conflict %b exp 0 0", fwd_hit[1], conflict[1]); end
    while (pop_idx < 6) begin
      #1;
      checks++; if (mem_req !== 1'b1 || mem_wa !== pa[pop_idx]) begin failures++; $display("FAIL wrap_drain[%0d]: req %b wa %h exp 1 %h", pop_idx, mem_req, mem_wa, pa[pop_idx]); end
      mem_ack = 1'b1;
      cycle();
      mem_ack = 1'b0;
      pop_idx++;
    end
    #1;
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL wrap_empty: got %b exp 1", empty); end
  endtask

  task automatic test_random();
    bit          e_hit, e_conf;
    logic [31:0] e_data;
    set_idle();
    for (int n = 0; n < 400; n++) begin
      we = ($urandom_range(0, 99) < 55);
      wa = 32'h1000 + 32'($urandom_range(0, 3) * 4) + ($urandom_range(0, 2) == 0 ? 32'($urandom_range(0, 3)) : 32'h0);
      wd = $urandom;
      wm = ($urandom_range(0, 2) == 0) ? ldst_mode'($urandom_range(0, 2)) : LDST_WORD;
      mem_ack = ($urandom_range(0, 99) < 45);
      for (int p = 0; p < 2; p++) begin
        la[p] = 32'h1000 + 32'($urandom_range(0, 4) * 4) + ($urandom_range(0, 2) == 0 ? 32'($urandom_range(0, 3)) : 32'h0);
        lm[p] = ($urandom_range(0, 2) == 0) ? ldst_mode'($urandom_range(0, 2)) : LDST_WORD;
      end
      #1;
      checks++; if (empty !== (model_q.size() == 0)) begin failures++; $display("FAIL rnd_empty @%0d: got %b exp %b", n, empty, model_q.size() == 0); end
      checks++; if (full !== (model_q.size() == DEPTH)) begin failures++; $display("FAIL rnd_full @%0d: got %b exp %b", n, full, model_q.size() == DEPTH); end
      checks++; if (mem_req !== (model_q.size() != 0)) begin failures++; $display("FAIL rnd_mem_req @%0d: got %b exp %b", n, mem_req, model_q.size() != 0); end
      checks++; if (overflow !== model_ovf) begin failures++; $display("FAIL rnd_overflow @%0d: got %b exp %b", n, overflow, model_ovf); end
      if (model_q.size() != 0) begin
        checks++; if (mem_wa !== model_q[0].addr || mem_wd !== model_q[0].data || mem_wm !== model_q[0].mode) begin failures++; $display("FAIL rnd_head @%0d: got %h/%h/%0d exp %h/%h/%0d", n, mem_wa, mem_wd, mem_wm, model_q[0].addr, model_q[0].data, model_q[0].mode); end
      end
      for (int p = 0; p < 2; p++) begin
        model_lookup(la[p], lm[p], e_hit, e_conf, e_data);
        checks++; if (fwd_hit[p] !== e_hit || conflict[p] !== e_conf) begin failures++; $display("FAIL rnd_lookup[%0d] @%0d: hit %b conflict %b exp %b %b", p, n, fwd_hit[p], conflict[p], e_hit, e_conf); end
        if (!e_conf) begin
          checks++; if (fwd_data[p] !== e_data) begin failures++; $display("FAIL rnd_fwd_data[%0d] @%0d: got %h exp %h", p, n, fwd_data[p], e_data); end
        end
      end
      cycle();
    end
    set_idle();
  endtask

  task automatic test_reset_mid();
    do_reset();
    push_word(32'h900, 32'h9);
    push_word(32'h904, 32'hA);
    push_word(32'h908, 32'hB);
    la[0] = 32'h900; lm[0] = LDST_WORD;
    #1;
    checks++; if (mem_req !== 1'b1) begin failures++; $display("FAIL rmid_pending: mem_req %b exp 1", mem_req); end
    #1;
    rst_n = 1'b0;
    #1;
    checks++; if (empty !== 1'b1 || mem_req !== 1'b0) begin failures++; $display("FAIL rmid_async: empty %b mem_req %b exp 1 0", empty, mem_req); end
    checks++; if (overflow !== 1'b0 || full !== 1'b0) begin failures++; $display("FAIL rmid_status: overflow %b full %b exp 0 0", overflow, full); end
    checks++; if (fwd_hit[0] !== 1'b0 || conflict[0] !== 1'b0) begin failures++; $display("FAIL rmid_lookup: hit %b conflict %b exp 0 0", fwd_hit[0], conflict[0]); end
    model_q.delete();
    model_ovf = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 3; n++) begin
      #1;
      checks++; if (mem_req !== 1'b0 || empty !== 1'b1) begin failures++; $display("FAIL rmid_stale[%0d]: mem_req %b empty %b exp 0 1", n, mem_req, empty); end
      cycle();
    end
  endtask

  initial begin
    model_ovf = 1'b0;
    test_reset();
    test_single_push();
    test_full_overflow();
    test_full_push_pop();
    test_forwarding();
    test_wrap();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/store_buffer.md
STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of buffered stores (power of two, >=2).
REQ-002 SHALL have parameter DEPTH_LOG, default 2, equal to log2(DEPTH).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low; 0 = reset asserted.
REQ-005 SHALL have port we  input  1  commit-stage store enable.
REQ-006 SHALL have port wa  input  32  store address.
REQ-007 SHALL have port wd  input  32  store data.
REQ-008 SHALL have port wm  input  ldst_mode  store width mode.
REQ-009 SHALL have port la[2]  input  32  load lookup addresses from the two execute load ports.
REQ-010 SHALL have port lm[2]  input  ldst_mode  load lookup modes.
REQ-011 SHALL have port fwd_hit[2]  output  1  lookup forwardable from the buffer.
REQ-012 SHALL have port fwd_data[2]  output  32  forwarded data; valid when fwd_hit.
REQ-013 SHALL have port conflict[2]  output  1  word overlap that cannot be forwarded; load must retry.
REQ-014 SHALL have port mem_req  output  1  drain request to memory.
REQ-015 SHALL have port mem_wa / mem_wd  output  32 each  head entry address / data.
REQ-016 SHALL have port mem_wm  output  ldst_mode  head entry mode.
REQ-017 SHALL have port mem_ack  input  1  memory accepted the current request.
REQ-018 SHALL have ports full, empty, overflow  output  1 each  status.

Function
REQ-019 SHALL hold entries in a circular FIFO with head/tail pointers of DEPTH_LOG+1 bits; wrap at DEPTH, MSB distinguishes full from empty.
REQ-020 SHALL assert empty when head==tail and full when indices match and MSBs differ; both combinational from pointers.
REQ-021 SHALL enqueue {wa,wd,wm} at tail on the edge where we=1 and (full=0 or pop occurs that cycle).
REQ-022 SHALL drop a store with we=1, full=1 and no pop that cycle, and set overflow sticky to 1.
REQ-023 SHALL drive mem_req = !empty, with mem_wa/mem_wd/mem_wm = head entry, combinationally.
REQ-024 SHALL pop the head on the edge where mem_req=1 and mem_ack=1; mem_ack with mem_req=0 SHALL be ignored.
REQ-025 SHALL keep mem_req and head fields stable until acked (no reordering, no cancellation).
REQ-026 SHALL allow simultaneous push and pop; count unchanged, both pointers advance.
REQ-027 SHALL compare, per load port independently, la[i][31:2] against wa[31:2] of every valid entry; same-cycle we input not searched.
REQ-028 SHALL select the youngest (closest to tail) matching entry when several match.
REQ-029 SHALL set fwd_hit[i]=1, fwd_data[i]=its wd, conflict[i]=0 when the youngest match has wa==la[i] and wm==lm[i].
REQ-030 SHALL set conflict[i]=1, fwd_hit[i]=0 when a youngest match exists but address or mode differs.
REQ-031 SHALL drive fwd_hit[i]=0, conflict[i]=0, fwd_data[i]=0 when no valid entry matches.
REQ-032 SHALL treat lookups as purely combinational (zero-cycle latency); entry being popped this cycle still participates.

Reset
REQ-033 SHALL, while reset=0, clear head, tail and overflow asynchronously: empty=1, full=0, mem_req=0, fwd_hit=0, conflict=0.
REQ-034 SHALL discard all buffered stores on reset mid-operation; no request issued on the edge reset deasserts.
REQ-035 SHALL leave entry storage uninitialised; only validity is reset.

Verification
REQ-036 Push WORD 0x100/0xDEADBEEF, mem_ack=0 -> next cycle mem_req=1, mem_wa=0x100, mem_wd=0xDEADBEEF, empty=0; la[0]=0x100,WORD -> fwd_hit[0]=1, fwd_data[0]=0xDEADBEEF.
REQ-037 Push 4 stores, mem_ack=0 -> full=1; 5th we -> dropped, overflow=1; then ack 4 times -> stores drained in push order, empty=1.
REQ-038 Full, we=1 and mem_ack=1 same cycle -> new store accepted, full stays 1, overflow stays 0, head advances.
REQ-039 Push WORD 0x200/0x11111111 then WORD 0x200/0x22222222 -> lookup 0x200 WORD returns 0x22222222; lookup 0x202 HALF -> conflict=1, fwd_hit=0; lookup 0x300 -> both 0.
REQ-040 Push 6 stores with acks interleaved so pointers wrap -> FIFO order and forwarding correct after wrap.
REQ-041 Assert reset=0 with 3 entries pending mid-request -> immediately empty=1, mem_req=0, overflow=0; after release, no stale drain.
